// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared definitions for the program loader: default geometry,
//               the NOP fill word and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int              DEFAULT_ISA_WIDTH = 16;
    localparam int              DEFAULT_DEPTH     = 32;
    localparam logic [15:0]     NOP_INST          = 16'h0000;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_ARM     = 3'd1,
        ST_BURST   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RUN     = 3'd4
    } loader_state_e;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_buf.sv
`default_nettype none
// ============================================================================
// Module      : loader_buf
// Description : DEPTH x ISA_WIDTH instruction staging buffer.
//               One synchronous write port, one combinational read port.
//               Contents are deliberately not reset.
// Ports       : clk        - rising-edge clock
//               i_wr_en    - write strobe
//               i_wr_addr  - write slot
//               i_wr_data  - word to store
//               i_rd_addr  - read slot
//               o_rd_data  - word at i_rd_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module loader_buf
    import loader_pkg::*;
#(
    parameter int ISA_WIDTH = DEFAULT_ISA_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [ISA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [ISA_WIDTH-1:0] o_rd_data
);

    logic [ISA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : loader_buf
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Collects a program as a byte stream (high byte first), packs
//               it into instruction words, then bursts exactly DEPTH words
//               (padding with PAD_INST) into the instruction memory while
//               its PC is released, holds, and finally releases the PC to run.
// Options     : LOADER_CHECKSUM_EN - build the running XOR checksum of stored
//               words; when undefined, checksum is tied to 0.
// Ports       : clk, rst            - clock, async active-high reset
//               byte_valid/data     - program byte stream in
//               byte_ready          - byte accepted this cycle
//               flush               - end of program, start burst
//               run                 - release PC after the burst
//               icmem_rst_n         - active-low PC reset to instruction mem
//               inst_wen/input_inst - instruction write port (registered)
//               inst_count          - words collected
//               done                - burst complete, awaiting run
//               checksum            - XOR of stored words
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int                   ISA_WIDTH = DEFAULT_ISA_WIDTH,
    parameter int                   DEPTH     = DEFAULT_DEPTH,
    parameter logic [ISA_WIDTH-1:0] PAD_INST  = ISA_WIDTH'(NOP_INST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    input  logic                     flush,
    input  logic                     run,
    output logic                     icmem_rst_n,
    output logic                     inst_wen,
    output logic [ISA_WIDTH-1:0]     input_inst,
    output logic [$clog2(DEPTH):0]   inst_count,
    output logic                     done,
    output logic [ISA_WIDTH-1:0]     checksum
);

    localparam int                 c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int                 c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(DEPTH - 1);

    loader_state_e        r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_count, w_count_nxt;
    logic [c_cnt_w-1:0]   r_idx, w_idx_nxt;
    logic                 r_hi_pend, w_hi_pend_nxt;
    logic [7:0]           r_hi_byte, w_hi_byte_nxt;
    logic                 w_wr_en;
    logic [15:0]          w_word;
    logic [ISA_WIDTH-1:0] w_wr_data;
    logic [ISA_WIDTH-1:0] w_rd_data;
    logic [ISA_WIDTH-1:0] w_inst_nxt;
    logic                 w_full;
    logic                 w_xfer;
    logic                 r_wen, r_rst_n, r_done;
    logic [ISA_WIDTH-1:0] r_inst;

    assign w_full     = (r_count == c_depth);
    assign byte_ready = (r_state == ST_COLLECT) && !w_full;
    assign w_xfer     = byte_valid && byte_ready;
    assign w_wr_data  = ISA_WIDTH'(w_word);

    loader_buf #(
        .ISA_WIDTH (ISA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (c_addr_w)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_count[c_addr_w-1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_idx_nxt[c_addr_w-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_idx_nxt     = r_idx;
        w_hi_pend_nxt = r_hi_pend;
        w_hi_byte_nxt = r_hi_byte;
        w_wr_en       = 1'b0;
        w_word        = '0;

        case (r_state)
            ST_COLLECT: begin
                // At most one word is stored per cycle: a byte arriving with
                // flush is absorbed first, and a lone high byte is padded.
                if (w_xfer) begin
                    if (r_hi_pend) begin
                        w_wr_en       = 1'b1;
                        w_word        = {r_hi_byte, byte_data};
                        w_hi_pend_nxt = 1'b0;
                        w_count_nxt   = r_count + c_cnt_w'(1);
                    end else if (flush) begin
                        w_wr_en     = 1'b1;
                        w_word      = {byte_data, 8'h00};
                        w_count_nxt = r_count + c_cnt_w'(1);
                    end else begin
                        w_hi_pend_nxt = 1'b1;
                        w_hi_byte_nxt = byte_data;
                    end
                end else if (flush && r_hi_pend) begin
                    w_wr_en       = 1'b1;
                    w_word        = {r_hi_byte, 8'h00};
                    w_hi_pend_nxt = 1'b0;
                    w_count_nxt   = r_count + c_cnt_w'(1);
                end
                if (w_full || (flush && ((r_count != '0) || r_hi_pend || w_xfer))) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                w_state_nxt = ST_BURST;
                w_idx_nxt   = '0;
            end
            ST_BURST: begin
                if (r_idx == c_last) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_idx_nxt = r_idx + c_cnt_w'(1);
                end
            end
            ST_HOLD: begin
                if (run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase

        // Outputs are registered, so they are derived from the next state:
        // the word presented in burst cycle k is fetched one cycle early.
        w_inst_nxt = '0;
        if (w_state_nxt == ST_BURST) begin
            w_inst_nxt = (w_idx_nxt < r_count) ? w_rd_data : PAD_INST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_COLLECT;
            r_count   <= '0;
            r_idx     <= '0;
            r_hi_pend <= 1'b0;
            r_hi_byte <= '0;
            r_wen     <= 1'b0;
            r_rst_n   <= 1'b0;
            r_done    <= 1'b0;
            r_inst    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_idx     <= w_idx_nxt;
            r_hi_pend <= w_hi_pend_nxt;
            r_hi_byte <= w_hi_byte_nxt;
            r_wen     <= (w_state_nxt == ST_BURST);
            r_rst_n   <= (w_state_nxt == ST_BURST) || (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_HOLD);
            r_inst    <= w_inst_nxt;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [ISA_WIDTH-1:0] r_checksum;

    // Only real stored words enter the checksum; PAD_INST fill never does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_wr_en) begin
            r_checksum <= r_checksum ^ w_wr_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign icmem_rst_n = r_rst_n;
    assign inst_wen    = r_wen;
    assign input_inst  = r_inst;
    assign done        = r_done;
    assign inst_count  = r_count;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader (default
//               parameters). Expected checksum values follow the
//               LOADER_CHECKSUM_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int          c_depth = 32;
    localparam logic [15:0] c_pad   = 16'h0000;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        flush;
    logic        run;
    logic        icmem_rst_n;
    logic        inst_wen;
    logic [15:0] input_inst;
    logic [5:0]  inst_count;
    logic        done;
    logic [15:0] checksum;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_mem [c_depth];
    logic [15:0] ck_model;

    prog_loader u_dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .flush       (flush),
        .run         (run),
        .icmem_rst_n (icmem_rst_n),
        .inst_wen    (inst_wen),
        .input_inst  (input_inst),
        .inst_count  (inst_count),
        .done        (done),
        .checksum    (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_ck(input logic [15:0] v);
`ifdef LOADER_CHECKSUM_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        flush      = 1'b0;
        run        = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Waits (bounded) for the first write cycle, then checks every one of the
    // DEPTH write cycles and the HOLD cycle that follows.
    task automatic check_burst(input int n_words);
        int t;
        t = 0;
        while (inst_wen !== 1'b1 && t < 8) begin
            step();
            t++;
        end
        chk("burst_start", inst_wen, 1);
        for (int k = 0; k < c_depth; k++) begin
            chk($sformatf("burst_wen_%0d", k), inst_wen, 1);
            chk($sformatf("burst_inst_%0d", k), input_inst,
                (k < n_words) ? exp_mem[k] : c_pad);
            if (k == 0) chk("burst_rst_n", icmem_rst_n, 1);
            step();
        end
        chk("hold_wen", inst_wen, 0);
        chk("hold_done", done, 1);
        chk("hold_rst_n", icmem_rst_n, 0);
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        flush      = 1'b0;
        run        = 1'b0;

        // Reset state
        step();
        chk("rst_byte_ready", byte_ready, 1);
        chk("rst_icmem_rst_n", icmem_rst_n, 0);
        chk("rst_inst_wen", inst_wen, 0);
        chk("rst_input_inst", input_inst, 0);
        chk("rst_done", done, 0);
        chk("rst_inst_count", inst_count, 0);
        chk("rst_checksum", checksum, 0);
        rst = 1'b0;
        step();

        // Full program of 32 words, automatic ARM, then run
        ck_model = 16'h0000;
        for (int k = 0; k < c_depth; k++) begin
            exp_mem[k] = {8'h12 + 8'(k), 8'h34 + 8'(k)};
            ck_model   = ck_model ^ exp_mem[k];
        end
        for (int k = 0; k < c_depth; k++) begin
            send_byte(exp_mem[k][15:8]);
            send_byte(exp_mem[k][7:0]);
        end
        chk("full_count", inst_count, 32);
        chk("full_ready", byte_ready, 0);
        chk("full_checksum", checksum, exp_ck(ck_model));
        chk("full_word0_model", exp_mem[0], 16'h1234);
        check_burst(c_depth);
        chk("full_ck_after_pad", checksum, exp_ck(ck_model));
        run = 1'b1;
        step();
        run = 1'b0;
        chk("run_rst_n", icmem_rst_n, 1);
        chk("run_done", done, 0);
        chk("run_wen", inst_wen, 0);
        send_byte(8'h55);
        pulse_flush();
        step();
        chk("run_ready", byte_ready, 0);
        chk("run_count", inst_count, 32);
        chk("run_rst_n_kept", icmem_rst_n, 1);
        chk("run_wen_kept", inst_wen, 0);

        // Partial program: 3 words then flush; run ignored outside HOLD
        do_reset();
        run = 1'b1;
        step();
        run = 1'b0;
        chk("early_run_rst_n", icmem_rst_n, 0);
        chk("early_run_ready", byte_ready, 1);
        exp_mem[0] = 16'h0102;
        exp_mem[1] = 16'h0304;
        exp_mem[2] = 16'h0506;
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        chk("part_count", inst_count, 3);
        pulse_flush();
        chk("arm_ready", byte_ready, 0);
        chk("arm_wen", inst_wen, 0);
        chk("arm_rst_n", icmem_rst_n, 0);
        step();
        chk("arm_one_cycle", inst_wen, 1);
        check_burst(3);
        pulse_flush();
        chk("hold_flush_done", done, 1);
        chk("hold_flush_wen", inst_wen, 0);

        // Odd byte count: pending high byte padded at flush
        do_reset();
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        chk("odd_count_pre", inst_count, 1);
        pulse_flush();
        chk("odd_count", inst_count, 2);
        chk("odd_checksum", checksum, exp_ck(16'h44CD));
        exp_mem[0] = 16'hABCD;
        exp_mem[1] = 16'hEF00;
        check_burst(2);

        // Flush with nothing collected is ignored; byte+flush same cycle
        do_reset();
        pulse_flush();
        step();
        chk("empty_flush_ready", byte_ready, 1);
        chk("empty_flush_wen", inst_wen, 0);
        chk("empty_flush_count", inst_count, 0);
        send_byte(8'h01);
        byte_valid = 1'b1;
        byte_data  = 8'h02;
        flush      = 1'b1;
        step();
        byte_valid = 1'b0;
        flush      = 1'b0;
        chk("same_cycle_count", inst_count, 1);
        exp_mem[0] = 16'h0102;
        check_burst(1);

        do_reset();
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        flush      = 1'b1;
        step();
        byte_valid = 1'b0;
        flush      = 1'b0;
        chk("hi_flush_count", inst_count, 1);
        exp_mem[0] = 16'h7700;
        check_burst(1);

        // Reset in burst cycle 10 aborts immediately
        do_reset();
        send_byte(8'h9A);
        send_byte(8'hBC);
        pulse_flush();
        begin
            int t;
            t = 0;
            while (inst_wen !== 1'b1 && t < 8) begin
                step();
                t++;
            end
        end
        chk("abort_k0", input_inst, 16'h9ABC);
        for (int k = 0; k < 10; k++) step();
        chk("abort_k10_wen", inst_wen, 1);
        chk("abort_k10_inst", input_inst, c_pad);
        rst = 1'b1;
        #1;
        chk("abort_wen", inst_wen, 0);
        chk("abort_rst_n", icmem_rst_n, 0);
        chk("abort_ready", byte_ready, 1);
        chk("abort_count", inst_count, 0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("abort_wen_after", inst_wen, 0);
        chk("abort_done_after", done, 0);

        // Checksum of complementary words
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        chk("ck_value", checksum, exp_ck(16'hFFFF));
        chk("ck_count", inst_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
